// File: rtl/gba_io_mem_pkg.sv
// Shared types and defaults for the two-master BRAM front end (mem_arb).
//   mem_cmd_t   : BRAM command encoding (idle/read/write)
//   size_t      : access size encoding (3 behaves as word)
//   arb_state_t : arbiter FSM states
//   req_hdr_t   : latched request payload (word address kept separately)
package gba_io_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DEPTH_DEF  = 32'h8820;

  typedef enum logic [1:0] {
    CMD_IDLE  = 2'b00,
    CMD_READ  = 2'b01,
    CMD_WRITE = 2'b10
  } mem_cmd_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RD_DONE  = 3'd2,
    RMW_WAIT = 3'd3,
    RMW_WR   = 3'd4
  } arb_state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic [1:0]  lane;
    logic [31:0] wdata;
  } req_hdr_t;

  // Anything that is not byte or half is handled as a full word.
  function automatic logic is_word(input logic [1:0] s);
    return !((s == SZ_BYTE) || (s == SZ_HALF));
  endfunction

endpackage

// File: rtl/mem_arb_lane.sv
// Combinational lane helper shared by the read and read-modify-write paths.
//   rd_word : word returned by the BRAM
//   wdata   : right-justified write data
//   lane    : byte address bits [1:0] (halfwords aligned down, words ignore it)
//   size    : access size (size_t encoding, 3 = word)
//   ext_c   : selected lane(s) right-justified and zero-extended
//   merge_c : rd_word with the addressed lane(s) replaced by wdata
module mem_arb_lane
  import gba_io_mem_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  output logic [31:0] ext_c,
  output logic [31:0] merge_c
);

  logic [1:0]  eff_lane;
  logic [4:0]  shamt;
  logic [31:0] mask;

  // Size selects the lane mask; the lane becomes a bit shift.
  always_comb begin
    eff_lane = 2'b00;
    mask     = 32'hFFFF_FFFF;
    case (size)
      SZ_BYTE: begin
        eff_lane = lane;
        mask     = 32'h0000_00FF;
      end
      SZ_HALF: begin
        eff_lane = {lane[1], 1'b0};
        mask     = 32'h0000_FFFF;
      end
      default: begin
        eff_lane = 2'b00;
        mask     = 32'hFFFF_FFFF;
      end
    endcase
    shamt   = {eff_lane, 3'b000};
    ext_c   = (rd_word >> shamt) & mask;
    merge_c = (rd_word & ~(mask << shamt)) | ((wdata & mask) << shamt);
  end

endmodule

// File: rtl/mem_arb.sv
// Two-master round-robin front end for the word-wide BRAM `mem`.
// Port A (bus bridge) and port B (host loader) issue byte/half/word requests
// held until ack; sub-word writes become BRAM read-modify-write.
//   clk, rst                 : clock, asynchronous active-low reset
//   {a,b}_req/we/size/addr/wdata : request inputs (byte address, right-justified data)
//   {a,b}_ack, {a,b}_rdata   : one-cycle completion pulse, zero-extended read data
//   mem_cmd/mem_addr/mem_wr_data : BRAM command port
//   mem_rd_data              : BRAM read word, valid the cycle after a READ
// Optional: GBA_IO_MEM_ARB_STATS_EN adds stat_a_grants, stat_b_grants and
// stat_conflicts (16-bit saturating counters).
module mem_arb
  import gba_io_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [1:0]        a_size,
  input  logic [ADDR_W+1:0] a_addr,
  input  logic [31:0]       a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [1:0]        b_size,
  input  logic [ADDR_W+1:0] b_addr,
  input  logic [31:0]       b_wdata,
  output logic              a_ack,
  output logic [31:0]       a_rdata,
  output logic              b_ack,
  output logic [31:0]       b_rdata,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wr_data,
  input  logic [31:0]       mem_rd_data
`ifdef GBA_IO_MEM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_a_grants,
  output logic [15:0]       stat_b_grants,
  output logic [15:0]       stat_conflicts
`endif
);

  arb_state_t        state_q, state_d;
  logic              ptr_q, ptr_d;     // 1: B has priority on a tie
  logic              port_q, port_d;   // 1: current transaction belongs to B
  logic              oor_q, oor_d;
  req_hdr_t          hdr_q, hdr_d;

  mem_cmd_t          cmd_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [31:0]       mem_wr_data_d;
  logic              a_ack_d, b_ack_d;
  logic [31:0]       a_rdata_d, b_rdata_d;

  logic              any_req;
  logic              sel_b;
  req_hdr_t          sel_hdr;
  logic [ADDR_W+1:0] sel_addr;
  logic [ADDR_W-1:0] sel_waddr;
  logic              sel_oor;
  logic [31:0]       ext_c, merge_c;

  // Round-robin select: a lone requester wins, a tie goes to the pointer.
  assign any_req   = a_req | b_req;
  assign sel_b     = b_req & (~a_req | ptr_q);
  assign sel_addr  = sel_b ? b_addr : a_addr;
  assign sel_waddr = sel_addr[ADDR_W+1:2];
  assign sel_oor   = 32'(sel_waddr) >= DEPTH;

  always_comb begin
    sel_hdr.we    = sel_b ? b_we    : a_we;
    sel_hdr.size  = sel_b ? b_size  : a_size;
    sel_hdr.lane  = sel_addr[1:0];
    sel_hdr.wdata = sel_b ? b_wdata : a_wdata;
  end

  mem_arb_lane u_lane (
    .rd_word (mem_rd_data),
    .wdata   (hdr_q.wdata),
    .lane    (hdr_q.lane),
    .size    (hdr_q.size),
    .ext_c   (ext_c),
    .merge_c (merge_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state; out-of-range requests ride the read timeline with no command.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          if (sel_oor || !sel_hdr.we)  state_d = RD_WAIT;
          else if (is_word(sel_hdr.size)) state_d = RD_DONE;
          else                         state_d = RMW_WAIT;
        end
      end
      RD_WAIT:  state_d = RD_DONE;
      RD_DONE:  state_d = IDLE;
      RMW_WAIT: state_d = RMW_WR;
      RMW_WR:   state_d = RD_DONE;
      default:  state_d = IDLE;
    endcase
  end

  // Output and capture values for the next edge.
  always_comb begin
    cmd_d         = CMD_IDLE;
    mem_addr_d    = mem_addr;
    mem_wr_data_d = mem_wr_data;
    a_ack_d       = 1'b0;
    b_ack_d       = 1'b0;
    a_rdata_d     = a_rdata;
    b_rdata_d     = b_rdata;
    ptr_d         = ptr_q;
    port_d        = port_q;
    oor_d         = oor_q;
    hdr_d         = hdr_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          ptr_d  = ~sel_b;
          port_d = sel_b;
          oor_d  = sel_oor;
          hdr_d  = sel_hdr;
          if (!sel_oor) begin
            mem_addr_d = sel_waddr;
            if (sel_hdr.we && is_word(sel_hdr.size)) begin
              cmd_d         = CMD_WRITE;
              mem_wr_data_d = sel_hdr.wdata;
            end else begin
              cmd_d = CMD_READ;
            end
          end
        end
      end
      RMW_WR: begin
        // mem_addr still holds the word address from the grant.
        cmd_d         = CMD_WRITE;
        mem_wr_data_d = merge_c;
      end
      RD_DONE: begin
        a_ack_d = ~port_q;
        b_ack_d = port_q;
        if (!hdr_q.we) begin
          if (port_q) b_rdata_d = oor_q ? 32'h0 : ext_c;
          else        a_rdata_d = oor_q ? 32'h0 : ext_c;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and latched request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_cmd     <= CMD_IDLE;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      a_rdata     <= '0;
      b_rdata     <= '0;
      ptr_q       <= 1'b0;
      port_q      <= 1'b0;
      oor_q       <= 1'b0;
      hdr_q       <= '0;
    end else begin
      mem_cmd     <= cmd_d;
      mem_addr    <= mem_addr_d;
      mem_wr_data <= mem_wr_data_d;
      a_ack       <= a_ack_d;
      b_ack       <= b_ack_d;
      a_rdata     <= a_rdata_d;
      b_rdata     <= b_rdata_d;
      ptr_q       <= ptr_d;
      port_q      <= port_d;
      oor_q       <= oor_d;
      hdr_q       <= hdr_d;
    end
  end

`ifdef GBA_IO_MEM_ARB_STATS_EN
  logic in_idle;
  assign in_idle = state_q == IDLE;

  // Saturating grant and conflict counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_a_grants  <= '0;
      stat_b_grants  <= '0;
      stat_conflicts <= '0;
    end else begin
      if (in_idle && any_req && !sel_b && stat_a_grants != 16'hFFFF)
        stat_a_grants <= stat_a_grants + 16'd1;
      if (in_idle && sel_b && stat_b_grants != 16'hFFFF)
        stat_b_grants <= stat_b_grants + 16'd1;
      if (in_idle && a_req && b_req && stat_conflicts != 16'hFFFF)
        stat_conflicts <= stat_conflicts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: a BRAM model with 1-cycle read latency,
// per-port expected-result queues filled at request time and drained on ack,
// and a command log for checking what reached the BRAM port.
module tb_mem_arb;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DEPTH  = 32'h8820;

  logic              clk = 1'b0;
  logic              rst;
  logic              a_req, a_we, b_req, b_we;
  logic [1:0]        a_size, b_size;
  logic [ADDR_W+1:0] a_addr, b_addr;
  logic [31:0]       a_wdata, b_wdata;
  logic              a_ack, b_ack;
  logic [31:0]       a_rdata, b_rdata;
  logic [1:0]        mem_cmd;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wr_data;
  logic [31:0]       mem_rd_data = 32'h0;

  mem_arb #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_size(a_size), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_size(b_size), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata), .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] rdata;
    bit          rd;
    int          issued;
    int          lat;
  } exp_t;

  typedef struct {
    logic [1:0]  cmd;
    logic [15:0] addr;
    logic [31:0] data;
  } cmd_ev_t;

  exp_t    qa[$];
  exp_t    qb[$];
  cmd_ev_t cmd_log[$];
  logic [31:0] bram [0:DEPTH-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: commands sampled on the edge after issue, read data one cycle later.
  always @(posedge clk) begin
    if (mem_cmd == 2'b01 && 32'(mem_addr) < DEPTH) mem_rd_data <= bram[mem_addr];
    else if (mem_cmd == 2'b10 && 32'(mem_addr) < DEPTH) bram[mem_addr] = mem_wr_data;
  end

  // Monitor: drain scoreboards on ack, log commands, check command/ack shape.
  logic [1:0] prev_cmd = 2'b00;
  logic       prev_a_ack = 1'b0, prev_b_ack = 1'b0;
  exp_t       mon_e;
  always @(negedge clk) begin
    if (rst) begin
      if (a_ack) begin
        if (prev_a_ack) chk("a_ack_pulse", 32'(prev_a_ack), 32'h0);
        if (qa.size() == 0) chk("a_spurious_ack", 32'(qa.size()), 32'h1);
        else begin
          mon_e = qa.pop_front();
          if (mon_e.rd) chk("a_rdata", a_rdata, mon_e.rdata);
          chk("a_latency", 32'(cyc - mon_e.issued), 32'(mon_e.lat));
        end
      end
      if (b_ack) begin
        if (prev_b_ack) chk("b_ack_pulse", 32'(prev_b_ack), 32'h0);
        if (qb.size() == 0) chk("b_spurious_ack", 32'(qb.size()), 32'h1);
        else begin
          mon_e = qb.pop_front();
          if (mon_e.rd) chk("b_rdata", b_rdata, mon_e.rdata);
          chk("b_latency", 32'(cyc - mon_e.issued), 32'(mon_e.lat));
        end
      end
      if (prev_cmd != 2'b00 && mem_cmd != 2'b00 && !(prev_cmd == 2'b01 && mem_cmd == 2'b10))
        chk("cmd_back_to_back", 32'({prev_cmd, mem_cmd}), 32'h0);
      if (mem_cmd != 2'b00) cmd_log.push_back('{mem_cmd, mem_addr, mem_wr_data});
      prev_cmd   = mem_cmd;
      prev_a_ack = a_ack;
      prev_b_ack = b_ack;
    end else begin
      prev_cmd   = 2'b00;
      prev_a_ack = 1'b0;
      prev_b_ack = 1'b0;
    end
  end

  // Drive one request (called on a negedge), hold it until ack, then drop it.
  task automatic req(input bit p, input bit we, input logic [1:0] size,
                     input logic [17:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, input int lat);
    exp_t e;
    bit   seen;
    seen     = 1'b0;
    e.rdata  = exp_rd;
    e.rd     = !we;
    e.issued = cyc;
    e.lat    = lat;
    if (p) begin
      b_we = we; b_size = size; b_addr = addr; b_wdata = wdata; b_req = 1'b1;
      qb.push_back(e);
    end else begin
      a_we = we; a_size = size; a_addr = addr; a_wdata = wdata; a_req = 1'b1;
      qa.push_back(e);
    end
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = p ? b_ack : a_ack;
    end
    if (!seen) chk(p ? "b_ack_timeout" : "a_ack_timeout", 32'(seen), 32'h1);
    if (p) b_req = 1'b0;
    else   a_req = 1'b0;
  endtask

  task automatic chk_log(input int idx, input logic [1:0] cmd, input logic [15:0] addr,
                         input logic [31:0] data, input bit with_data);
    if (cmd_log.size() <= idx) chk("log_missing", 32'(cmd_log.size()), 32'(idx + 1));
    else begin
      chk("log_cmd", 32'(cmd_log[idx].cmd), 32'(cmd));
      chk("log_addr", 32'(cmd_log[idx].addr), 32'(addr));
      if (with_data) chk("log_data", cmd_log[idx].data, data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_size = 2'd0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_size = 2'd0; b_addr = '0; b_wdata = '0;
    for (int i = 0; i < int'(DEPTH); i++) bram[i] = 32'h0;
    bram[0] = 32'hAABBCCDD;
    bram[1] = 32'h11223344;
    bram[4] = 32'hDEADBEEF;

    repeat (2) @(negedge clk);
    chk("rst_mem_cmd", 32'(mem_cmd), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wr_data", mem_wr_data, 32'h0);
    chk("rst_a_ack", 32'(a_ack), 32'h0);
    chk("rst_b_ack", 32'(b_ack), 32'h0);
    chk("rst_a_rdata", a_rdata, 32'h0);
    chk("rst_b_rdata", b_rdata, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Simultaneous requests from reset: A, then B (A still asking), then A.
    cmd_log.delete();
    fork
      begin
        req(0, 0, 2'd2, 18'h00010, 32'h0, 32'hDEADBEEF, 3);
        req(0, 0, 2'd2, 18'h00000, 32'h0, 32'hAABBCCDD, 6);
      end
      req(1, 0, 2'd2, 18'h00004, 32'h0, 32'h11223344, 6);
    join
    chk_log(0, 2'b01, 16'd4, 32'h0, 1'b0);
    chk_log(1, 2'b01, 16'd1, 32'h0, 1'b0);
    chk_log(2, 2'b01, 16'd0, 32'h0, 1'b0);
    chk("b_rdata_held", b_rdata, 32'h11223344);

    // B served alone, then a tie must go to A.
    @(negedge clk);
    req(1, 0, 2'd2, 18'h00010, 32'h0, 32'hDEADBEEF, 3);
    @(negedge clk);
    fork
      req(0, 0, 2'd0, 18'h00011, 32'h0, 32'h000000BE, 3);
      req(1, 0, 2'd0, 18'h00012, 32'h0, 32'h000000AD, 6);
    join

    // Plain word read.
    @(negedge clk);
    cmd_log.delete();
    req(0, 0, 2'd2, 18'h00010, 32'h0, 32'hDEADBEEF, 3);
    chk("word_rd_log_n", 32'(cmd_log.size()), 32'h1);
    chk_log(0, 2'b01, 16'd4, 32'h0, 1'b0);

    // Byte write via read-modify-write; junk upper data bits must be ignored.
    @(negedge clk);
    cmd_log.delete();
    req(1, 1, 2'd0, 18'h00007, 32'hFFFFFF5A, 32'h0, 4);
    chk("rmw_log_n", 32'(cmd_log.size()), 32'h2);
    chk_log(0, 2'b01, 16'd1, 32'h0, 1'b0);
    chk_log(1, 2'b10, 16'd1, 32'h5A223344, 1'b1);
    chk("rmw_bram", bram[1], 32'h5A223344);
    @(negedge clk);
    req(1, 0, 2'd2, 18'h00004, 32'h0, 32'h5A223344, 3);

    // Sub-word reads: misaligned half aligns down, byte lane 1.
    @(negedge clk);
    req(0, 0, 2'd1, 18'h00003, 32'h0, 32'h0000AABB, 3);
    @(negedge clk);
    req(1, 0, 2'd0, 18'h00005, 32'h0, 32'h00000033, 3);

    // Half write into upper lane, then readback.
    @(negedge clk);
    req(0, 1, 2'd1, 18'h00002, 32'hFFFF1234, 32'h0, 4);
    @(negedge clk);
    req(0, 0, 2'd2, 18'h00000, 32'h0, 32'h1234CCDD, 3);

    // Size 3 behaves as a word write.
    @(negedge clk);
    cmd_log.delete();
    req(1, 1, 2'd3, 18'h00008, 32'hCAFEF00D, 32'h0, 2);
    chk("w3_log_n", 32'(cmd_log.size()), 32'h1);
    chk_log(0, 2'b10, 16'd2, 32'hCAFEF00D, 1'b1);
    @(negedge clk);
    req(1, 0, 2'd2, 18'h00008, 32'h0, 32'hCAFEF00D, 3);

    // Last in-range word.
    @(negedge clk);
    req(0, 1, 2'd2, 18'h2207C, 32'h13579BDF, 32'h0, 2);
    @(negedge clk);
    req(0, 0, 2'd2, 18'h2207C, 32'h0, 32'h13579BDF, 3);

    // First out-of-range word: no BRAM command, read returns 0.
    @(negedge clk);
    cmd_log.delete();
    req(0, 1, 2'd2, 18'h22080, 32'hFFFFFFFF, 32'h0, 3);
    @(negedge clk);
    req(0, 1, 2'd0, 18'h22081, 32'hFFFFFFFF, 32'h0, 3);
    @(negedge clk);
    req(0, 0, 2'd2, 18'h22080, 32'h0, 32'h0, 3);
    chk("oor_log_n", 32'(cmd_log.size()), 32'h0);

    // Reset while the RMW read is outstanding.
    @(negedge clk);
    b_we = 1'b1; b_size = 2'd0; b_addr = 18'h00004; b_wdata = 32'h00000077; b_req = 1'b1;
    @(negedge clk);
    chk("rmw_read_issued", 32'(mem_cmd), 32'h1);
    rst = 1'b0;
    b_req = 1'b0;
    #1;
    chk("rst_mid_mem_cmd", 32'(mem_cmd), 32'h0);
    chk("rst_mid_b_ack", 32'(b_ack), 32'h0);
    repeat (3) @(negedge clk);
    chk("rst_mid_no_ack", 32'(b_ack), 32'h0);
    chk("rst_mid_bram", bram[1], 32'h5A223344);
    rst = 1'b1;
    @(negedge clk);
    req(0, 0, 2'd2, 18'h00004, 32'h0, 32'h5A223344, 3);
    repeat (3) @(negedge clk);

    chk("qa_drained", 32'(qa.size()), 32'h0);
    chk("qb_drained", 32'(qb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
